// File: rtl/timer_pkg.sv
// Shared FSM state type, mode encodings and default sizes for the timeout counter.
// Imported by the interface, the prescaler and the counter top.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_PRESCALE_W = 4;

    // Magnitude compare so that a limit lowered below the current value
    // still terminates immediately instead of waiting for a wrap.
    function automatic logic is_terminal(input logic [31:0] value, input logic [31:0] limit);
        return value >= limit;
    endfunction

endpackage

// File: rtl/prog_timeout_counter_if.sv
// Control/status bundle of the programmable timeout counter.
// The prescale field exists only when TIMER_PRESCALE_EN is defined.
interface prog_timeout_counter_if
    import timer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
);

    logic             count;
    logic             clear;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] limit;
`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale;
`endif
    logic             timeout;
    logic [WIDTH-1:0] value;
    logic             done;

`ifdef TIMER_PRESCALE_EN
    modport master (
        output count, clear, start, mode, limit, prescale,
        input  timeout, value, done
    );
    modport slave (
        input  count, clear, start, mode, limit, prescale,
        output timeout, value, done
    );
`else
    modport master (
        output count, clear, start, mode, limit,
        input  timeout, value, done
    );
    modport slave (
        input  count, clear, start, mode, limit,
        output timeout, value, done
    );
`endif

endinterface

// File: rtl/timer_prescaler.sv
// Count-enable divider: tick fires on every (ratio+1)-th enabled cycle.
// Only compiled and used when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] ratio,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_reg;

    // >= keeps a ratio lowered mid-count from forcing a full wrap.
    assign tick = en && (cnt_reg >= ratio);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr || tick) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/prog_timeout_counter.sv
// Programmable timeout counter: periodic or one-shot, terminal value = limit.
// Optional count-enable prescaler selected by the TIMER_PRESCALE_EN macro.
module prog_timeout_counter
    import timer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    prog_timeout_counter_if.slave bus
);

    timer_state_t     state_reg;
    logic [WIDTH-1:0] value_reg;
    logic             timeout_reg;
    logic             done_reg;

    logic tick;
    logic arm;
    logic terminal;

    // start is only honoured outside RUN; a start during RUN never restarts.
    assign arm      = bus.start && (state_reg != RUN);
    assign terminal = tick && (state_reg == RUN)
                      && is_terminal(32'(value_reg), 32'(bus.limit));

`ifdef TIMER_PRESCALE_EN
    logic prescale_en;
    logic prescale_clr;

    assign prescale_en  = bus.count && (state_reg == RUN);
    assign prescale_clr = bus.clear || arm || terminal;

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (prescale_en),
        .clr   (prescale_clr),
        .ratio (bus.prescale),
        .tick  (tick)
    );
`else
    assign tick = bus.count;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            value_reg   <= '0;
            timeout_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else if (bus.clear) begin
            state_reg   <= IDLE;
            value_reg   <= '0;
            timeout_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    value_reg   <= '0;
                    timeout_reg <= 1'b0;
                    done_reg    <= 1'b0;
                    if (arm) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    done_reg <= 1'b0;
                    if (terminal) begin
                        value_reg   <= '0;
                        timeout_reg <= 1'b1;
                        if (bus.mode == MODE_ONESHOT) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        timeout_reg <= 1'b0;
                        if (tick) begin
                            value_reg <= value_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    value_reg   <= '0;
                    timeout_reg <= 1'b0;
                    if (arm) begin
                        state_reg <= RUN;
                        done_reg  <= 1'b0;
                    end else begin
                        done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    value_reg   <= '0;
                    timeout_reg <= 1'b0;
                    done_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.value   = value_reg;
    assign bus.timeout = timeout_reg;
    assign bus.done    = done_reg;

endmodule

// File: tb/tb_prog_timeout_counter.sv
// Scoreboard bench for prog_timeout_counter (WIDTH=8); covers the prescaler
// scenario too when built with TIMER_PRESCALE_EN.
module tb_prog_timeout_counter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    prog_timeout_counter_if #(.WIDTH(8), .PRESCALE_W(4)) bus ();

    prog_timeout_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] value;
        logic       timeout;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    int   pulse_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state: 0 idle, 1 run, 2 done
    int m_state;
    int m_value;
    bit m_timeout;
    bit m_done;
    int m_pcnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_value   = 0;
        m_timeout = 0;
        m_done    = 0;
        m_pcnt    = 0;
    endtask

    task automatic drive(input bit c, input bit clr, input bit s);
        bus.count = c;
        bus.clear = clr;
        bus.start = s;
    endtask

    // Advance the model, push its prediction, clock the DUT and compare.
    task automatic step(input string tag);
        exp_t e;
        bit   tick;
        bit   arm;
        int   st;
        st   = m_state;
        arm  = bus.start && (st != 1);
        tick = bus.count;
`ifdef TIMER_PRESCALE_EN
        tick = bus.count && (st == 1) && (m_pcnt >= int'(bus.prescale));
        if (bus.clear || arm || tick) m_pcnt = 0;
        else if (bus.count && st == 1) m_pcnt = m_pcnt + 1;
`endif
        if (bus.clear) begin
            m_state = 0; m_value = 0; m_timeout = 0; m_done = 0;
        end else if (st == 0) begin
            m_value = 0; m_timeout = 0; m_done = 0;
            if (bus.start) m_state = 1;
        end else if (st == 1) begin
            m_timeout = 0;
            m_done    = 0;
            if (tick) begin
                if (m_value >= int'(bus.limit)) begin
                    m_value   = 0;
                    m_timeout = 1;
                    if (bus.mode) begin
                        m_state = 2;
                        m_done  = 1;
                    end
                end else begin
                    m_value = m_value + 1;
                end
            end
        end else begin
            m_value = 0; m_timeout = 0; m_done = 1;
            if (bus.start) begin
                m_state = 1;
                m_done  = 0;
            end
        end
        e.value   = 8'(m_value);
        e.timeout = m_timeout;
        e.done    = m_done;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check_eq({tag, ".value"},   32'(bus.value),   32'(e.value));
        check_eq({tag, ".timeout"}, 32'(bus.timeout), 32'(e.timeout));
        check_eq({tag, ".done"},    32'(bus.done),    32'(e.done));
        if (bus.timeout) pulse_q.push_back(cyc);
        $display("txn %0d %s value=%0d timeout=%0b done=%0b", cyc, tag, bus.value, bus.timeout, bus.done);
        @(negedge clk);
    endtask

    task automatic check_gaps(input string tag, input int n_exp, input int gap);
        check_eq({tag, ".pulses"}, 32'(pulse_q.size()), 32'(n_exp));
        for (int i = 1; i < pulse_q.size(); i++) begin
            check_eq({tag, ".gap"}, 32'(pulse_q[i] - pulse_q[i-1]), 32'(gap));
        end
    endtask

    initial begin
        reset     = 1'b0;
        bus.mode  = 1'b0;
        bus.limit = 8'd0;
`ifdef TIMER_PRESCALE_EN
        bus.prescale = 4'd0;
`endif
        drive(0, 0, 0);
        model_reset();
        #12;
        check_eq("rst.value",   32'(bus.value),   32'd0);
        check_eq("rst.timeout", 32'(bus.timeout), 32'd0);
        check_eq("rst.done",    32'(bus.done),    32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Periodic, limit 9: three pulses ten cycles apart
        bus.limit = 8'd9; bus.mode = 1'b0;
        drive(0, 0, 1); step("per_start");
        pulse_q.delete();
        drive(1, 0, 0);
        for (int i = 0; i < 30; i++) step("per_run");
        check_gaps("per", 3, 10);

        // One-shot, limit 4
        drive(0, 1, 0); step("clr");
        bus.limit = 8'd4; bus.mode = 1'b1;
        drive(0, 0, 1); step("os_start");
        pulse_q.delete();
        drive(1, 0, 0);
        for (int i = 0; i < 8; i++) step("os_run");
        check_gaps("os", 1, 0);
        if (pulse_q.size() > 0) check_eq("os.first", 32'(pulse_q[0] - (cyc - 8)), 32'd5);
        drive(1, 0, 1); step("os_rearm");
        drive(1, 0, 0);
        for (int i = 0; i < 3; i++) step("os_rerun");

        // Limit lowered below the running value
        drive(0, 1, 0); step("clr");
        bus.limit = 8'd200; bus.mode = 1'b0;
        drive(0, 0, 1); step("low_start");
        drive(1, 0, 0);
        for (int i = 0; i < 150; i++) step("low_run");
        check_eq("low.at150", 32'(bus.value), 32'd150);
        bus.limit = 8'd100;
        step("low_cut");
        check_eq("low.pulse", 32'(bus.timeout), 32'd1);
        step("low_after");

        // Gated count, limit 3
        drive(0, 1, 0); step("clr");
        bus.limit = 8'd3;
        drive(0, 0, 1); step("gate_start");
        pulse_q.delete();
        for (int i = 0; i < 10; i++) begin
            drive((i % 2) == 0, 0, 0);
            step("gate_run");
        end
        check_gaps("gate", 1, 0);

        // limit 0: pulse on every enabled cycle; start during RUN ignored
        drive(0, 1, 0); step("clr");
        bus.limit = 8'd0;
        drive(0, 0, 1); step("z_start");
        pulse_q.delete();
        drive(1, 0, 0);
        for (int i = 0; i < 4; i++) step("z_run");
        check_gaps("zero", 4, 1);
        bus.limit = 8'd9;
        drive(1, 0, 0); step("rs_run");
        drive(1, 0, 1); step("rs_start_in_run");
        drive(1, 0, 0); step("rs_run");

        // Switch to one-shot mid-run
        bus.mode = 1'b1; bus.limit = 8'd2;
        for (int i = 0; i < 4; i++) step("mode_sw");

        // Asynchronous reset with value at 5
        drive(0, 1, 0); step("clr");
        bus.limit = 8'd9; bus.mode = 1'b0;
        drive(0, 0, 1); step("ar_start");
        drive(1, 0, 0);
        for (int i = 0; i < 5; i++) step("ar_run");
        #2;
        reset = 1'b0;
        #1;
        check_eq("ar.value",   32'(bus.value),   32'd0);
        check_eq("ar.timeout", 32'(bus.timeout), 32'd0);
        check_eq("ar.done",    32'(bus.done),    32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step("ar_idle");

        // clear wins over start and count
        drive(1, 1, 1); step("clr_start");
        drive(1, 0, 0); step("clr_idle");

`ifdef TIMER_PRESCALE_EN
        drive(0, 1, 0); step("clr");
        bus.prescale = 4'd2; bus.limit = 8'd1; bus.mode = 1'b0;
        drive(0, 0, 1); step("ps_start");
        pulse_q.delete();
        drive(1, 0, 0);
        for (int i = 0; i < 18; i++) step("ps_run");
        check_gaps("ps", 3, 6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
